uart_rx_block: RTL and testbench



---
 rtl/uart_aes_pkg.sv | 20 ++
 rtl/uart_rx_byte.sv | 162 ++++++++++++++++
 rtl/uart_rx_block.sv | 127 ++++++++++++
 tb/tb_uart_rx_block.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_aes_pkg.sv
// Shared definitions for the UART-to-AES receive path.
// Contents:
//   rx_state_e           - receive FSM state encoding
//   DEFAULT_CLKS_PER_BIT - 100 MHz clock / 115200 baud
//   BLOCK_BYTES, BLOCK_W - AES block geometry (16 bytes, 128 bits)
package uart_aes_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int BLOCK_BYTES          = 16;
    localparam int BLOCK_W              = 128;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, bit timer, receive FSM and
// shift register.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high
//   rx_in      - asynchronous serial line, idle high
//   byte_data  - last byte shifted in (valid while byte_valid is high)
//   byte_valid - one-cycle strobe in the cycle the good stop bit is sampled
//   frame_err  - one-cycle strobe in the cycle a bad stop bit is sampled
//   busy       - registered; high from start-bit acceptance to stop sample
// byte_valid/frame_err are decodes of registered state so the parent can
// register them on the same edge the stop sample is taken.
module uart_rx_byte
    import uart_aes_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    logic               sync1_r;
    logic               sync2_r;
    logic               rx_s;
    rx_state_e          state_r;
    rx_state_e          state_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_s;
    logic [2:0]         bit_idx_r;
    logic [2:0]         bit_idx_s;
    logic [7:0]         shift_r;
    logic [7:0]         shift_s;
    logic               busy_r;
    logic               busy_s;
    logic               byte_valid_s;
    logic               frame_err_s;

    assign rx_s = sync2_r;

    // Synchroniser for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_in;
            sync2_r <= sync1_r;
        end
    end

    // FSM, bit timer, bit index, shift register and busy flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            timer_r   <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            busy_r    <= busy_s;
        end
    end

    // Next-state logic; the timer restarts at every sample point so each
    // sample lands mid-bit relative to the detected start edge.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r + TIMER_W'(1);
        bit_idx_s    = bit_idx_r;
        shift_s      = shift_r;
        busy_s       = busy_r;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            IDLE: begin
                timer_s = '0;
                if (!rx_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (timer_r == HALF_LAST) begin
                    timer_s = '0;
                    if (rx_s) begin
                        // Glitch shorter than half a bit: silently ignore.
                        state_s = IDLE;
                    end else begin
                        state_s   = DATA;
                        busy_s    = 1'b1;
                        bit_idx_s = 3'd0;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (timer_r == FULL_LAST) begin
                    timer_s   = '0;
                    shift_s   = {rx_s, shift_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (timer_r == FULL_LAST) begin
                    timer_s = '0;
                    busy_s  = 1'b0;
                    if (rx_s) begin
                        byte_valid_s = 1'b1;
                        state_s      = IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_s     = WAIT_IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not be taken as a new start.
                timer_s = '0;
                if (rx_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                timer_s = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign byte_data  = shift_r;
    assign byte_valid = byte_valid_s;
    assign frame_err  = frame_err_s;
    assign busy       = busy_r;

endmodule

// File: rtl/uart_rx_block.sv
// UART receiver that packs BYTES_PER_BLOCK consecutive 8N1 bytes into one
// AES block, first byte in the most significant byte.
// Optional feature macro: RX_TIMEOUT_EN (inter-byte idle timeout).
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high; discards any partial block
//   rx_in       - serial line from TOP_TX tx_out, idle high
//   block_out   - last completed block; held until the next one completes
//   block_valid - one-cycle pulse when block_out updates
//   frame_err   - one-cycle pulse on a bad stop bit (partial block dropped)
//   timeout_err - one-cycle pulse on inter-byte timeout (0 without macro)
//   busy        - high from start-bit acceptance until the stop sample
module uart_rx_block
    import uart_aes_pkg::*;
#(
    parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int BYTES_PER_BLOCK = BLOCK_BYTES,
    parameter int TIMEOUT_BITS    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_in,
    output logic [8*BYTES_PER_BLOCK-1:0] block_out,
    output logic                         block_valid,
    output logic                         frame_err,
    output logic                         timeout_err,
    output logic                         busy
);

    localparam int W     = 8 * BYTES_PER_BLOCK;
    localparam int CNT_W = $clog2(BYTES_PER_BLOCK + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_BLOCK - 1);

    logic [7:0]       byte_data_s;
    logic             byte_valid_s;
    logic             byte_ferr_s;
    logic             busy_s;
    logic             timeout_hit_s;
    logic [W-1:0]     pack_s;
    logic [CNT_W-1:0] byte_cnt_r;
    logic [W-1:0]     pack_r;
    logic [W-1:0]     block_out_r;
    logic             block_valid_r;
    logic             frame_err_r;
    logic             timeout_err_r;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .byte_data (byte_data_s),
        .byte_valid(byte_valid_s),
        .frame_err (byte_ferr_s),
        .busy      (busy_s)
    );

    // Shifting left means byte k ends up at [W-1-8k -: 8] once all are in.
    always_comb begin
        pack_s = (pack_r << 8) | W'(byte_data_s);
    end

`ifdef RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    logic [TO_W-1:0] idle_cnt_r;

    // Idle time is measured while no byte is in flight (busy low), which
    // also covers a false start between bytes of a partial block.
    assign timeout_hit_s = !busy_s && (byte_cnt_r != '0) &&
                           (idle_cnt_r == TO_W'(TO_LIMIT - 1));

    // Inter-byte idle counter; cleared by an accepted start or an empty block.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_r <= '0;
        end else if (busy_s || (byte_cnt_r == '0) || timeout_hit_s) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + TO_W'(1);
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Byte counter, packing register and registered block/error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_r    <= '0;
            pack_r        <= '0;
            block_out_r   <= '0;
            block_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            block_valid_r <= 1'b0;
            frame_err_r   <= byte_ferr_s;
            timeout_err_r <= timeout_hit_s;
            if (byte_ferr_s) begin
                byte_cnt_r <= '0;
            end else if (byte_valid_s) begin
                pack_r <= pack_s;
                if (byte_cnt_r == LAST_BYTE) begin
                    byte_cnt_r    <= '0;
                    block_out_r   <= pack_s;
                    block_valid_r <= 1'b1;
                end else begin
                    byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                end
            end else if (timeout_hit_s) begin
                byte_cnt_r <= '0;
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end
        end
    end

    assign block_out   = block_out_r;
    assign block_valid = block_valid_r;
    assign frame_err   = frame_err_r;
    assign timeout_err = timeout_err_r;
    assign busy        = busy_s;

endmodule

// File: tb/tb_uart_rx_block.sv
// Self-checking bench for uart_rx_block (CLKS_PER_BIT=16, TIMEOUT_BITS=4).
// Table of per-byte vectors for the basic block, hand-written sequences for
// false start, framing error, reset mid-frame and inter-byte timeout.
module tb_uart_rx_block;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        int         exp_blocks;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx_in = 1'b1;
    logic [127:0] block_out;
    logic         block_valid;
    logic         frame_err;
    logic         timeout_err;
    logic         busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int stop_cyc = 0;

    int           blk_cnt = 0;
    int           ferr_cnt = 0;
    int           tout_cnt = 0;
    int           busy_cnt = 0;
    int           dbl_cnt = 0;
    int           last_valid_cyc = 0;
    logic         prev_valid = 1'b0;
    logic [127:0] last_blk = '0;

    vec_t vec[16];

    uart_rx_block #(
        .CLKS_PER_BIT(CPB),
        .BYTES_PER_BLOCK(16),
        .TIMEOUT_BITS(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .block_out  (block_out),
        .block_valid(block_valid),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (block_valid) begin
            blk_cnt = blk_cnt + 1;
            last_blk = block_out;
            last_valid_cyc = cyc;
        end
        if (block_valid && prev_valid) dbl_cnt = dbl_cnt + 1;
        prev_valid = block_valid;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (timeout_err) tout_cnt = tout_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        stop_cyc = cyc;
        send_bit(stop);
    endtask

    function automatic logic [127:0] place(input logic [127:0] blk, input int k, input logic [7:0] b);
        logic [127:0] r;
        r = blk;
        r[127 - 8*k -: 8] = b;
        return r;
    endfunction

    initial begin
        logic [127:0] exp_blk;
        logic [127:0] prev_blk;
        int           exp_blocks;
        int           busy_snap;

        for (int i = 0; i < 16; i++) begin
            vec[i].data = 8'(i);
            vec[i].exp_blocks = (i == 15) ? 1 : 0;
        end

        // 1. Reset with idle line.
        #1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_block_out", block_out, 128'h0);
        check("rst_block_valid", {127'h0, block_valid}, 128'h0);
        check("rst_frame_err", {127'h0, frame_err}, 128'h0);
        check("rst_timeout_err", {127'h0, timeout_err}, 128'h0);
        check("rst_busy", {127'h0, busy}, 128'h0);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("idle_no_pulses", 128'(blk_cnt + ferr_cnt + tout_cnt + busy_cnt), 128'h0);

        // 2. Single block from the vector table.
        for (int i = 0; i < 16; i++) begin
            send_byte(vec[i].data, 1'b1);
            check($sformatf("blk_count_byte%0d", i), 128'(blk_cnt), 128'(vec[i].exp_blocks));
        end
        check("single_block", last_blk, 128'h000102030405060708090A0B0C0D0E0F);
        check("single_block_out", block_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("single_busy_after", {127'h0, busy}, 128'h0);
        check("valid_width", 128'(dbl_cnt), 128'h0);
        check("valid_latency_ok",
              {127'h0, (last_valid_cyc - stop_cyc >= 8) && (last_valid_cyc - stop_cyc <= 14)},
              128'h1);
        exp_blocks = 1;

        // 3. False start: 4 low cycles.
        busy_snap = busy_cnt;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("false_start_busy", 128'(busy_cnt - busy_snap), 128'h0);
        check("false_start_ferr", 128'(ferr_cnt), 128'h0);
        exp_blk = '0;
        exp_blk = place(exp_blk, 0, 8'h5A);
        send_byte(8'h5A, 1'b1);
        for (int k = 1; k < 16; k++) begin
            exp_blk = place(exp_blk, k, 8'(8'h10 + k));
            send_byte(8'(8'h10 + k), 1'b1);
        end
        exp_blocks = exp_blocks + 1;
        check("false_start_blocks", 128'(blk_cnt), 128'(exp_blocks));
        check("false_start_block", block_out, exp_blk);
        prev_blk = exp_blk;

        // 4. Framing error with a 3-bit-time low line.
        for (int k = 0; k < 5; k++) send_byte(8'(k + 1), 1'b1);
        send_byte(8'hA5, 1'b0);
        busy_snap = busy_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        check("ferr_pulse_once", 128'(ferr_cnt), 128'h1);
        check("ferr_wait_idle_no_busy", 128'(busy_cnt - busy_snap), 128'h0);
        check("ferr_block_held", block_out, prev_blk);
        send_bit(1'b1);
        exp_blk = '0;
        for (int k = 0; k < 16; k++) begin
            exp_blk = place(exp_blk, k, 8'(8'hC0 + k));
            send_byte(8'(8'hC0 + k), 1'b1);
            if (k == 14) check("ferr_block_unchanged_b15", block_out, prev_blk);
        end
        exp_blocks = exp_blocks + 1;
        check("ferr_recover_blocks", 128'(blk_cnt), 128'(exp_blocks));
        check("ferr_recover_block", block_out, exp_blk);

        // 5. Reset during data bits of byte 3.
        for (int k = 0; k < 3; k++) send_byte(8'(8'h70 + k), 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx_in = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_block_out", block_out, 128'h0);
        check("midrst_busy", {127'h0, busy}, 128'h0);
        reset = 1'b0;
        send_bit(1'b1);
        check("midrst_no_valid", 128'(blk_cnt), 128'(exp_blocks));
        exp_blk = '0;
        for (int k = 0; k < 16; k++) begin
            exp_blk = place(exp_blk, k, 8'(8'h80 + k));
            send_byte(8'(8'h80 + k), 1'b1);
        end
        exp_blocks = exp_blocks + 1;
        check("midrst_blocks", 128'(blk_cnt), 128'(exp_blocks));
        check("midrst_block", block_out, exp_blk);

        // 6. Inter-byte timeout.
        exp_blk = '0;
        exp_blk = place(exp_blk, 0, 8'h11);
        exp_blk = place(exp_blk, 1, 8'h22);
        exp_blk = place(exp_blk, 2, 8'h33);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        repeat (5) send_bit(1'b1);
`ifdef RX_TIMEOUT_EN
        check("timeout_pulse", 128'(tout_cnt), 128'h1);
        for (int k = 0; k < 16; k++) send_byte(8'hFF, 1'b1);
        exp_blk = {128{1'b1}};
`else
        check("timeout_tied_zero", 128'(tout_cnt), 128'h0);
        for (int k = 3; k < 16; k++) begin
            exp_blk = place(exp_blk, k, 8'hFF);
            send_byte(8'hFF, 1'b1);
        end
`endif
        exp_blocks = exp_blocks + 1;
        check("timeout_blocks", 128'(blk_cnt), 128'(exp_blocks));
        check("timeout_block", block_out, exp_blk);
        check("final_valid_width", 128'(dbl_cnt), 128'h0);
        check("final_ferr_total", 128'(ferr_cnt), 128'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
